// File: rtl/sre_pkg.sv
// rtl/sre_pkg.sv - shared types, MISR constants and response fold helper for stim_resp_engine
//
// Contents:
//   sre_state_t  - engine FSM state encoding
//   MISR_POLY    - MISR feedback polynomial (shift-left form)
//   MISR_SEED    - MISR value after reset and at every run start
//   FOLD_MAX_W   - widest response the fold helper accepts
//   fold()       - XOR of 32-bit chunks of a zero-padded response
package sre_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_APPLY   = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } sre_state_t;

    localparam logic [31:0] MISR_POLY  = 32'h04C1_1DB7;
    localparam logic [31:0] MISR_SEED  = 32'hFFFF_FFFF;
    localparam int          FOLD_MAX_W = 1024;

    // Callers zero-extend their response to FOLD_MAX_W, which gives the
    // zero-padded most-significant chunk for free.
    function automatic logic [31:0] fold(input logic [FOLD_MAX_W-1:0] d);
        logic [31:0] f;
        f = '0;
        for (int i = 0; i < FOLD_MAX_W / 32; i++) begin
            f = f ^ d[i*32 +: 32];
        end
        return f;
    endfunction

endpackage

// File: rtl/sre_misr.sv
// rtl/sre_misr.sv - 32-bit multiple-input signature register over captured responses
//
// Ports:
//   clk   in   clock, rising edge
//   rst   in   asynchronous active-high reset (loads MISR_SEED)
//   init  in   reload MISR_SEED (run start)
//   en    in   fold data into the signature this cycle
//   data  in   OUT_W response being captured
//   sig   out  current signature
import sre_pkg::*;

module sre_misr #(
    parameter int OUT_W = 123
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init,
    input  logic             en,
    input  logic [OUT_W-1:0] data,
    output logic [31:0]      sig
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig <= MISR_SEED;
        end else if (init) begin
            sig <= MISR_SEED;
        end else if (en) begin
            sig <= {sig[30:0], 1'b0}
                 ^ (sig[31] ? MISR_POLY : 32'h0)
                 ^ fold(FOLD_MAX_W'(data));
        end
    end

endmodule

// File: rtl/stim_resp_engine.sv
// rtl/stim_resp_engine.sv - on-chip stimulus player and response capture engine
//
// Optional feature macro: MISR_EN (adds sre_misr signature compaction;
// without it signature is tied to zero).
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   ld_valid/addr/data  stimulus memory write, accepted only while ld_ready
//   ld_ready            high while the FSM is idle
//   start, num_vec      begin a run of min(num_vec, DEPTH) vectors
//   abort               drop the run and return to idle, no done pulse
//   busy                run in progress (includes the done cycle)
//   done                one-cycle pulse at normal run end
//   dut_in              registered stimulus to the circuit under test
//   dut_out             circuit response
//   resp_valid/idx/data one-cycle pulse per captured response
//   signature           MISR value
import sre_pkg::*;

module stim_resp_engine #(
    parameter int IN_W   = 178,
    parameter int OUT_W  = 123,
    parameter int DEPTH  = 8,
    parameter int AW     = $clog2(DEPTH),
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_valid,
    input  logic [AW-1:0]    ld_addr,
    input  logic [IN_W-1:0]  ld_data,
    output logic             ld_ready,
    input  logic             start,
    input  logic [AW:0]      num_vec,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [IN_W-1:0]  dut_in,
    input  logic [OUT_W-1:0] dut_out,
    output logic             resp_valid,
    output logic [AW-1:0]    resp_idx,
    output logic [OUT_W-1:0] resp_data,
    output logic [31:0]      signature
);

    localparam logic [AW:0] DEPTH_N      = (AW+1)'(DEPTH);
    localparam logic [7:0]  SETTLE_LAST  = 8'(SETTLE - 1);

    sre_state_t state, state_d;

    logic [IN_W-1:0] mem [DEPTH];
    logic [AW:0]     n_q;
    logic [AW-1:0]   idx;
    logic [7:0]      cnt;
    logic [AW:0]     n_clamp;
    logic            run_go;
    logic            last_vec;

    assign n_clamp  = (num_vec > DEPTH_N) ? DEPTH_N : num_vec;
    assign run_go   = (state == ST_IDLE) && start && !abort;
    assign last_vec = ({1'b0, idx} == (n_q - 1'b1));
    assign ld_ready = (state == ST_IDLE);
    // done is registered one cycle behind the DONE state, so busy is held
    // through it to fall only once the pulse is over.
    assign busy     = (state != ST_IDLE) || done;

    always_ff @(posedge clk) begin
        if (ld_valid && ld_ready && (32'(ld_addr) < DEPTH)) begin
            mem[ld_addr] <= ld_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // A zero-length run still goes through APPLY (which then leaves dut_in
    // alone), so an empty run reports done two cycles after start.
    always_comb begin
        state_d = state;
        if (abort && (state != ST_IDLE)) begin
            state_d = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (run_go) state_d = ST_APPLY;
                end
                ST_APPLY: begin
                    if (n_q == '0)       state_d = ST_DONE;
                    else if (SETTLE > 0) state_d = ST_SETTLE;
                    else                 state_d = ST_CAPTURE;
                end
                ST_SETTLE: begin
                    if (cnt == SETTLE_LAST) state_d = ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    state_d = last_vec ? ST_DONE : ST_APPLY;
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dut_in     <= '0;
            resp_valid <= 1'b0;
            resp_idx   <= '0;
            resp_data  <= '0;
            done       <= 1'b0;
            n_q        <= '0;
            idx        <= '0;
            cnt        <= '0;
        end else begin
            resp_valid <= 1'b0;
            done       <= (state == ST_DONE) && !abort;
            case (state)
                ST_IDLE: begin
                    if (run_go) begin
                        n_q <= n_clamp;
                        idx <= '0;
                    end
                end
                ST_APPLY: begin
                    if (!abort && (n_q != '0)) begin
                        dut_in <= mem[idx];
                        cnt    <= '0;
                    end
                end
                ST_SETTLE: begin
                    if (!abort) cnt <= cnt + 8'd1;
                end
                ST_CAPTURE: begin
                    // abort in this cycle discards the capture entirely
                    if (!abort) begin
                        resp_data  <= dut_out;
                        resp_idx   <= idx;
                        resp_valid <= 1'b1;
                        if (!last_vec) idx <= idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef MISR_EN
    sre_misr #(
        .OUT_W (OUT_W)
    ) u_misr (
        .clk  (clk),
        .rst  (rst),
        .init (run_go),
        .en   ((state == ST_CAPTURE) && !abort),
        .data (dut_out),
        .sig  (signature)
    );
`else
    assign signature = 32'h0;
`endif

endmodule

// File: tb/tb_stim_resp_engine.sv
// tb/tb_stim_resp_engine.sv - self-checking bench for stim_resp_engine with an inverter as DUT
module tb_stim_resp_engine;

    localparam int IN_W   = 8;
    localparam int OUT_W  = 8;
    localparam int DEPTH  = 4;
    localparam int AW     = 2;
    localparam int SETTLE = 1;

    typedef struct {
        logic [AW-1:0]    idx;
        logic [OUT_W-1:0] data;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             ld_valid;
    logic [AW-1:0]    ld_addr;
    logic [IN_W-1:0]  ld_data;
    logic             ld_ready;
    logic             start;
    logic [AW:0]      num_vec;
    logic             abort;
    logic             busy;
    logic             done;
    logic [IN_W-1:0]  dut_in;
    logic [OUT_W-1:0] dut_out;
    logic             resp_valid;
    logic [AW-1:0]    resp_idx;
    logic [OUT_W-1:0] resp_data;
    logic [31:0]      signature;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int n_resp = 0;
    int n_done = 0;

    exp_t           exp_q[$];
    int             resp_cyc_q[$];
    logic [IN_W-1:0] model_mem [DEPTH];

    assign dut_out = ~dut_in;

    stim_resp_engine #(
        .IN_W   (IN_W),
        .OUT_W  (OUT_W),
        .DEPTH  (DEPTH),
        .AW     (AW),
        .SETTLE (SETTLE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ld_valid   (ld_valid),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .ld_ready   (ld_ready),
        .start      (start),
        .num_vec    (num_vec),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .dut_in     (dut_in),
        .dut_out    (dut_out),
        .resp_valid (resp_valid),
        .resp_idx   (resp_idx),
        .resp_data  (resp_data),
        .signature  (signature)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every response must match the head of the queue.
    always @(negedge clk) begin
        if (done) n_done++;
        if (resp_valid) begin
            exp_t e;
            n_resp++;
            resp_cyc_q.push_back(cyc);
            tests++;
            assert (exp_q.size() != 0) else begin
                fails++;
                $error("FAIL unexpected_resp: observed idx %0d data %0h expected no response", resp_idx, resp_data);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("resp_idx", 32'(resp_idx), 32'(e.idx));
                chk("resp_data", 32'(resp_data), 32'(e.data));
            end
        end
    end

    task automatic push_expected(input int nv);
        for (int i = 0; i < nv && i < DEPTH; i++) begin
            exp_t e;
            e.idx  = AW'(i);
            e.data = ~model_mem[i];
            exp_q.push_back(e);
        end
    endtask

    // Plays one run; lat is the number of edges from the start edge to done.
    task automatic run(input int nv, input bit inject, output int lat);
        int c0;
        bit seen;
        resp_cyc_q.delete();
        @(negedge clk);
        start   = 1'b1;
        num_vec = (AW+1)'(nv);
        push_expected(nv);
        @(negedge clk);
        start = 1'b0;
        c0    = cyc;
        seen  = 1'b0;
        lat   = -1;
        for (int k = 0; k < 60 && !seen; k++) begin
            if (done) begin
                seen = 1'b1;
                lat  = cyc - c0;
            end else begin
                if (inject && (cyc - c0 == 4)) begin
                    start    = 1'b1;
                    ld_valid = 1'b1;
                    ld_addr  = 2'd1;
                    ld_data  = 8'h77;
                end else begin
                    start    = 1'b0;
                    ld_valid = 1'b0;
                end
                @(negedge clk);
            end
        end
        start    = 1'b0;
        ld_valid = 1'b0;
        chk("run_done_seen", 32'(seen), 32'd1);
        chk("busy_during_done", 32'(busy), 32'd1);
        @(negedge clk);
        chk("busy_after_done", 32'(busy), 32'd0);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        for (int i = 0; i < resp_cyc_q.size(); i++) begin
            chk("resp_cycle", 32'(resp_cyc_q[i] - c0), 32'(3 * (i + 1)));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_dut_in"}, 32'(dut_in), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        chk({tag, "_resp_idx"}, 32'(resp_idx), 32'd0);
        chk({tag, "_resp_data"}, 32'(resp_data), 32'd0);
        chk({tag, "_ld_ready"}, 32'(ld_ready), 32'd1);
`ifdef MISR_EN
        chk({tag, "_signature"}, signature, 32'hFFFF_FFFF);
`else
        chk({tag, "_signature"}, signature, 32'h0);
`endif
    endtask

    initial begin
        int lat;
        int r0;
        int d0;
        logic [IN_W-1:0] vecs [DEPTH];

        vecs[0] = 8'h00; vecs[1] = 8'h0F; vecs[2] = 8'hA5; vecs[3] = 8'hFF;
        rst = 1'b1; ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
        start = 1'b0; num_vec = '0; abort = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // load the stimulus memory
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            ld_valid = 1'b1;
            ld_addr  = AW'(i);
            ld_data  = vecs[i];
            model_mem[i] = vecs[i];
        end
        @(negedge clk);
        ld_valid = 1'b0;

        // full run of four vectors
        r0 = n_resp;
        run(4, 1'b0, lat);
        chk("run4_latency", 32'(lat), 32'd13);
        chk("run4_resp_count", 32'(n_resp - r0), 32'd4);
        chk("run4_dut_in_hold", 32'(dut_in), 32'hFF);

        // empty run
        r0 = n_resp;
        run(0, 1'b0, lat);
        chk("run0_latency", 32'(lat), 32'd2);
        chk("run0_resp_count", 32'(n_resp - r0), 32'd0);
`ifdef MISR_EN
        chk("run0_signature", signature, 32'hFFFF_FFFF);
`else
        chk("run0_signature", signature, 32'h0);
`endif

        // oversized request, mid-run start and load are ignored
        r0 = n_resp;
        run(7, 1'b1, lat);
        chk("run7_latency", 32'(lat), 32'd13);
        chk("run7_resp_count", 32'(n_resp - r0), 32'd4);

        // start together with abort in idle does not begin a run
        @(negedge clk);
        start = 1'b1; abort = 1'b1; num_vec = 3'd2;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("start_abort_idle_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        chk("start_abort_idle_no_resp", 32'(exp_q.size()), 32'd0);

        // abort during the second settle cycle
        r0 = n_resp; d0 = n_done;
        @(negedge clk);
        start = 1'b1; num_vec = 3'd4;
        push_expected(1);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_busy_before", 32'(busy), 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy_after", 32'(busy), 32'd0);
        repeat (6) @(negedge clk);
        chk("abort_resp_count", 32'(n_resp - r0), 32'd1);
        chk("abort_no_done", 32'(n_done - d0), 32'd0);
        chk("abort_sb_empty", 32'(exp_q.size()), 32'd0);

        // reset asserted during the first capture
        @(negedge clk);
        start = 1'b1; num_vec = 3'd4;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_reset_dut_in", 32'(dut_in), 32'h00);
        rst = 1'b1;
        #1;
        check_reset_outputs("midrun_reset");
        @(negedge clk);
        rst = 1'b0;

        // replay without reload
        r0 = n_resp;
        run(4, 1'b0, lat);
        chk("replay_latency", 32'(lat), 32'd13);
        chk("replay_resp_count", 32'(n_resp - r0), 32'd4);

`ifdef MISR_EN
        run(1, 1'b0, lat);
        chk("misr_single_vec", signature, 32'hFB3E_E2B6);
`else
        chk("no_misr_signature", signature, 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
